// File: rtl/mem_rst_seq_pkg.sv
// Shared types and defaults for the DDR3 bring-up sequencer.
// The optional calibration-retry path is enabled with MEM_RST_SEQ_RETRY_EN.
package mem_rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK  = 3'd0,
        ST_STABLE     = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_SYS_DLY    = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAIL       = 3'd5
    } state_t;

    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_LOCK_STABLE_CYC   = 2400;
    localparam int DEF_CALIB_TIMEOUT_CYC = 2400000;
    localparam int DEF_SYS_RST_DLY_CYC   = 16;
    localparam int DEF_MAX_RETRY         = 3;

    // Width of the shared counter so it can reach the largest of the three limits.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mem_rst_seq_if.sv
// Sequencer-facing signal bundle: PLL/controller status in, reset and status out.
interface mem_rst_seq_if;
    logic       pll_lock;
    logic       init_calib_complete;
    logic       ddr_rst_n;
    logic       sys_rst_n;
    logic       init_done;
    logic       fail;
    logic [2:0] state_o;
    logic [1:0] retry_cnt;

    modport master (
        output pll_lock, init_calib_complete,
        input  ddr_rst_n, sys_rst_n, init_done, fail, state_o, retry_cnt
    );

    modport slave (
        input  pll_lock, init_calib_complete,
        output ddr_rst_n, sys_rst_n, init_done, fail, state_o, retry_cnt
    );
endinterface

// File: rtl/mem_rst_seq_sync_bit.sv
// STAGES-deep single-bit synchronizer with asynchronous active-low reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[STAGES-2:0], d};
    end

    assign q = sr[STAGES-1];
endmodule

// File: rtl/mem_rst_seq.sv
// DDR3 bring-up sequencer: PLL lock -> DDR controller reset release -> calibration -> user reset release.
// Define MEM_RST_SEQ_RETRY_EN to retry calibration timeouts up to MAX_RETRY times before FAIL.
//
// state       | meaning
// WAIT_LOCK   | waiting for synchronized PLL lock, everything held in reset
// STABLE      | lock seen, counting LOCK_STABLE_CYC before releasing the controller
// WAIT_CALIB  | controller released, waiting for calibration with timeout
// SYS_DLY     | calibration seen, short delay before releasing user logic
// RUN         | fully up
// FAIL        | calibration timed out; sticky until rst_n
module mem_rst_seq
    import mem_rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int LOCK_STABLE_CYC   = DEF_LOCK_STABLE_CYC,
    parameter int CALIB_TIMEOUT_CYC = DEF_CALIB_TIMEOUT_CYC,
    parameter int SYS_RST_DLY_CYC   = DEF_SYS_RST_DLY_CYC,
    parameter int MAX_RETRY         = DEF_MAX_RETRY
) (
    input logic          clk,
    input logic          rst_n,
    mem_rst_seq_if.slave bus
);
    localparam int CNT_W = cnt_width(LOCK_STABLE_CYC, CALIB_TIMEOUT_CYC, SYS_RST_DLY_CYC);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] DLY_LAST   = CNT_W'(SYS_RST_DLY_CYC - 1);

    logic             lock_s;
    logic             calib_s;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       retry_cnt;
    logic             ddr_rst_q, sys_rst_q, done_q, fail_q;
    logic             ddr_rst_d, sys_rst_d, done_d, fail_d;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk(clk), .rst_n(rst_n), .d(bus.pll_lock), .q(lock_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_calib (
        .clk(clk), .rst_n(rst_n), .d(bus.init_calib_complete), .q(calib_s)
    );

`ifdef MEM_RST_SEQ_RETRY_EN
    logic retry_inc;
    logic timeout_next_is_retry;

    assign timeout_next_is_retry = (retry_cnt < 2'(MAX_RETRY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            retry_cnt <= '0;
        else if (retry_inc && retry_cnt != '1) retry_cnt <= retry_cnt + 2'd1;
    end
`else
    logic unused_max_retry;

    assign unused_max_retry = ^2'(MAX_RETRY);
    assign retry_cnt        = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= '0;
            ddr_rst_q <= 1'b0;
            sys_rst_q <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state     <= state_next;
            ddr_rst_q <= ddr_rst_d;
            sys_rst_q <= sys_rst_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            // Counter restarts on every transition and only runs in the timed states.
            if (state_next != state || !(state inside {ST_STABLE, ST_WAIT_CALIB, ST_SYS_DLY}))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Priority inside each state: lock loss, then calibration seen, then timeout.
    always_comb begin
        state_next = state;
`ifdef MEM_RST_SEQ_RETRY_EN
        retry_inc  = 1'b0;
`endif
        case (state)
            ST_WAIT_LOCK:  if (lock_s) state_next = ST_STABLE;
            ST_STABLE: begin
                if (!lock_s)                state_next = ST_WAIT_LOCK;
                else if (cnt == LOCK_LAST)  state_next = ST_WAIT_CALIB;
            end
            ST_WAIT_CALIB: begin
                if (!lock_s)                state_next = ST_WAIT_LOCK;
                else if (calib_s)           state_next = ST_SYS_DLY;
                else if (cnt == CALIB_LAST) begin
`ifdef MEM_RST_SEQ_RETRY_EN
                    if (timeout_next_is_retry) begin
                        state_next = ST_WAIT_LOCK;
                        retry_inc  = 1'b1;
                    end else begin
                        state_next = ST_FAIL;
                    end
`else
                    state_next = ST_FAIL;
`endif
                end
            end
            ST_SYS_DLY: begin
                if (!lock_s)                state_next = ST_WAIT_LOCK;
                else if (cnt == DLY_LAST)   state_next = ST_RUN;
            end
            ST_RUN:        if (!lock_s || !calib_s) state_next = ST_WAIT_LOCK;
            ST_FAIL:       state_next = ST_FAIL;
            default:       state_next = ST_WAIT_LOCK;
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_comb begin
        ddr_rst_d = state_next inside {ST_WAIT_CALIB, ST_SYS_DLY, ST_RUN};
        sys_rst_d = (state_next == ST_RUN);
        done_d    = (state_next == ST_RUN);
        fail_d    = (state_next == ST_FAIL);
    end

    assign bus.ddr_rst_n = ddr_rst_q;
    assign bus.sys_rst_n = sys_rst_q;
    assign bus.init_done = done_q;
    assign bus.fail      = fail_q;
    assign bus.state_o   = state;
    assign bus.retry_cnt = retry_cnt;
endmodule

// File: tb/tb_mem_rst_seq.sv
// Directed bench for mem_rst_seq with shortened timing constants; covers both
// builds of MEM_RST_SEQ_RETRY_EN.
module tb_mem_rst_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ecnt = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    mem_rst_seq_if bus();

    mem_rst_seq #(
        .SYNC_STAGES(2),
        .LOCK_STABLE_CYC(8),
        .CALIB_TIMEOUT_CYC(32),
        .SYS_RST_DLY_CYC(4),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ddr, input logic sys, input logic done,
                            input logic fl, input logic [2:0] st, input logic [1:0] rc);
        chk({tag, "/ddr_rst_n"}, 32'(bus.ddr_rst_n), 32'(ddr));
        chk({tag, "/sys_rst_n"}, 32'(bus.sys_rst_n), 32'(sys));
        chk({tag, "/init_done"}, 32'(bus.init_done), 32'(done));
        chk({tag, "/fail"},      32'(bus.fail),      32'(fl));
        chk({tag, "/state_o"},   32'(bus.state_o),   32'(st));
        chk({tag, "/retry_cnt"}, 32'(bus.retry_cnt), 32'(rc));
    endtask

    // Advance to 1 time unit after the given edge, counted from the last reference point.
    task automatic to_edge(input int t);
        while (ecnt < t) begin
            @(posedge clk);
            ecnt++;
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pll_lock = 1'b0;
        bus.init_calib_complete = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ecnt = 0;
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        bus.init_calib_complete = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 0, 0, 0, 0, 3'd0, 2'd0);

        // Nominal bring-up
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ecnt = 0;
        bus.pll_lock = 1'b1;
        to_edge(10);
        chk_outs("nom_e10", 0, 0, 0, 0, 3'd1, 2'd0);
        to_edge(11);
        chk_outs("nom_e11", 1, 0, 0, 0, 3'd2, 2'd0);
        to_edge(21);
        bus.init_calib_complete = 1'b1;
        to_edge(27);
        chk_outs("nom_e27", 1, 0, 0, 0, 3'd3, 2'd0);
        to_edge(28);
        chk_outs("nom_run", 1, 1, 1, 0, 3'd4, 2'd0);

        // Lock loss in RUN, then relock repeats the nominal timing
        ecnt = 0;
        bus.pll_lock = 1'b0;
        bus.init_calib_complete = 1'b0;
        to_edge(2);
        chk_outs("loss_e2", 1, 1, 1, 0, 3'd4, 2'd0);
        to_edge(3);
        chk_outs("loss_e3", 0, 0, 0, 0, 3'd0, 2'd0);
        ecnt = 0;
        bus.pll_lock = 1'b1;
        to_edge(10);
        chk_outs("relock_e10", 0, 0, 0, 0, 3'd1, 2'd0);
        to_edge(11);
        chk_outs("relock_e11", 1, 0, 0, 0, 3'd2, 2'd0);
        to_edge(21);
        bus.init_calib_complete = 1'b1;
        to_edge(27);
        chk_outs("relock_e27", 1, 0, 0, 0, 3'd3, 2'd0);
        to_edge(28);
        chk_outs("relock_run", 1, 1, 1, 0, 3'd4, 2'd0);

        // Lock glitch of 3 cycles seen in STABLE at count 5
        do_reset();
        bus.pll_lock = 1'b1;
        to_edge(6);
        bus.pll_lock = 1'b0;
        to_edge(8);
        chk("glitch_e8/state_o", 32'(bus.state_o), 32'd1);
        to_edge(9);
        chk_outs("glitch_e9", 0, 0, 0, 0, 3'd0, 2'd0);
        bus.pll_lock = 1'b1;
        to_edge(11);
        chk_outs("glitch_e11", 0, 0, 0, 0, 3'd0, 2'd0);
        to_edge(12);
        chk("glitch_e12/state_o", 32'(bus.state_o), 32'd1);
        to_edge(19);
        chk_outs("glitch_e19", 0, 0, 0, 0, 3'd1, 2'd0);
        to_edge(20);
        chk_outs("glitch_e20", 1, 0, 0, 0, 3'd2, 2'd0);

        // Lock loss and calib rise land in the same synchronized cycle
        do_reset();
        bus.pll_lock = 1'b1;
        to_edge(13);
        chk("race_e13/state_o", 32'(bus.state_o), 32'd2);
        bus.pll_lock = 1'b0;
        bus.init_calib_complete = 1'b1;
        to_edge(15);
        chk("race_e15/state_o", 32'(bus.state_o), 32'd2);
        to_edge(16);
        chk_outs("race_e16", 0, 0, 0, 0, 3'd0, 2'd0);
        to_edge(17);
        chk_outs("race_e17", 0, 0, 0, 0, 3'd0, 2'd0);

        // Calibration never arrives
        do_reset();
        bus.pll_lock = 1'b1;
`ifdef MEM_RST_SEQ_RETRY_EN
        to_edge(42);
        chk_outs("to_e42", 1, 0, 0, 0, 3'd2, 2'd0);
        to_edge(43);
        chk_outs("to_e43", 0, 0, 0, 0, 3'd0, 2'd1);
        to_edge(52);
        chk_outs("to_e52", 1, 0, 0, 0, 3'd2, 2'd1);
        to_edge(83);
        chk_outs("to_e83", 1, 0, 0, 0, 3'd2, 2'd1);
        to_edge(84);
        chk_outs("to_e84", 0, 0, 0, 0, 3'd0, 2'd2);
        to_edge(124);
        chk_outs("to_e124", 1, 0, 0, 0, 3'd2, 2'd2);
        to_edge(125);
        chk_outs("to_fail", 0, 0, 0, 1, 3'd5, 2'd2);
`else
        to_edge(42);
        chk_outs("to_e42", 1, 0, 0, 0, 3'd2, 2'd0);
        to_edge(43);
        chk_outs("to_fail", 0, 0, 0, 1, 3'd5, 2'd0);
`endif
        ecnt = 0;
        bus.pll_lock = 1'b0;
        to_edge(5);
        bus.pll_lock = 1'b1;
        to_edge(16);
        chk("sticky/fail", 32'(bus.fail), 32'd1);
        chk("sticky/state_o", 32'(bus.state_o), 32'd5);

        // Asynchronous reset in the middle of WAIT_CALIB
        do_reset();
        chk_outs("rst_from_fail", 0, 0, 0, 0, 3'd0, 2'd0);
        bus.pll_lock = 1'b1;
`ifdef MEM_RST_SEQ_RETRY_EN
        to_edge(60);
        chk_outs("pre_arst", 1, 0, 0, 0, 3'd2, 2'd1);
`else
        to_edge(20);
        chk_outs("pre_arst", 1, 0, 0, 0, 3'd2, 2'd0);
`endif
        #3;
        rst_n = 1'b0;
        #1;
        chk_outs("arst", 0, 0, 0, 0, 3'd0, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
